traffic_sensor_debounce: RTL and testbench

//  Input-conditioning stage directly upstream of the traffic-light controller.

---
 rtl/traffic_sensor_debounce.sv | 130 +++++++++++++
 tb/tb_traffic_sensor_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_debounce.sv
// Vehicle-sensor conditioning: synchroniser, debounce FSM, latched car request and arrival counter.
// Optional feature: define CAR_COUNT_EN to build the saturating car_count counter (tied to 0 otherwise).
module traffic_sensor_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_raw,
  input  logic               req_ack,
  output logic               sensor_clean,
  output logic               car_req,
  output logic [COUNT_W-1:0] car_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_prev_q;
  logic                   rise;
  logic                   car_req_q, car_req_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      state_q      <= STABLE_LO;
      cnt_q        <= '0;
      clean_prev_q <= 1'b0;
      car_req_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sensor_raw};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clean_prev_q <= sensor_clean;
      car_req_q    <= car_req_d;
    end
  end

  // Next state: a change is accepted only after cnt reaches DEBOUNCE_CYCLES with sync still changed
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync) begin
          state_d = CONFIRM_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      CONFIRM_HI: begin
        if (!sync) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          state_d = CONFIRM_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      CONFIRM_LO: begin
        if (sync) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE_LO;
    endcase
  end

  // Outputs
  always_comb begin
    sensor_clean = (state_q == STABLE_HI) || (state_q == CONFIRM_LO);
    rise         = sensor_clean && !clean_prev_q;
    car_req_d    = car_req_q;
    if (rise) begin
      car_req_d = 1'b1;
    end else if (req_ack) begin
      car_req_d = 1'b0;
    end
  end

  assign car_req = car_req_q;

`ifdef CAR_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (rise && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign car_count = count_q;
`else
  assign car_count = '0;
`endif

endmodule

// File: tb/tb_traffic_sensor_debounce.sv
// Self-checking bench for traffic_sensor_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COUNT_W=8).
module tb_traffic_sensor_debounce;

  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int CW  = 8;
  localparam int LAT = SS + DC;
`ifdef CAR_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sensor_raw;
  logic          req_ack;
  logic          sensor_clean;
  logic          car_req;
  logic [CW-1:0] car_count;

  traffic_sensor_debounce #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .COUNT_W        (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_raw  (sensor_raw),
    .req_ack     (req_ack),
    .sensor_clean(sensor_clean),
    .car_req     (car_req),
    .car_count   (car_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic raw;
    logic ack;
    logic exp_clean;
    logic exp_req;
  } vec_t;

  typedef struct {
    logic  clean;
    logic  req;
    string tag;
  } exp_t;

  vec_t tbl1[8];
  vec_t tbl2[12];
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] exp);
    checks++;
    if (car_count !== exp) begin
      fails++;
      $display("FAIL %s: car_count got %0d, expected %0d", name, car_count, exp);
    end
  endtask

  // Drive one cycle, queue the expectation, compare after the edge
  task automatic step(input logic raw, input logic ack, input logic ec, input logic er,
                      input string tag);
    exp_t e;
    sensor_raw = raw;
    req_ack    = ack;
    e.clean    = ec;
    e.req      = er;
    e.tag      = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_bit({e.tag, "_clean"}, sensor_clean, e.clean);
    check_bit({e.tag, "_req"}, car_req, e.req);
  endtask

  task automatic drive(input logic raw, input int n);
    sensor_raw = raw;
    req_ack    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    sensor_raw = 1'b0;
    req_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    sensor_raw = 1'b0;
    req_ack    = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tbl1[i].raw       = 1'b1;
      tbl1[i].ack       = 1'b0;
      tbl1[i].exp_clean = (i >= LAT);
      tbl1[i].exp_req   = (i >= LAT + 1);
    end
    for (int i = 0; i < 12; i++) begin
      tbl2[i].raw       = (i < 3);
      tbl2[i].ack       = 1'b0;
      tbl2[i].exp_clean = 1'b0;
      tbl2[i].exp_req   = 1'b0;
    end

    // Reset state and basic latency
    do_reset();
    check_bit("rst_clean", sensor_clean, 1'b0);
    check_bit("rst_req", car_req, 1'b0);
    check_cnt("rst_cnt", '0);
    for (int i = 0; i < 8; i++) begin
      step(tbl1[i].raw, tbl1[i].ack, tbl1[i].exp_clean, tbl1[i].exp_req, $sformatf("t1_%0d", i));
    end
    check_cnt("t1_cnt", CNT_ON ? CW'(1) : CW'(0));

    // Short pulse is rejected
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl2[i].raw, tbl2[i].ack, tbl2[i].exp_clean, tbl2[i].exp_req, $sformatf("t2_%0d", i));
    end
    check_cnt("t2_cnt", '0);

    // Low glitch while high is filtered, then a real fall takes full latency
    do_reset();
    drive(1'b1, 8);
    check_bit("t3_pre_clean", sensor_clean, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, $sformatf("t3_glitch_%0d", i));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b1, $sformatf("t3_hold_%0d", i));
    for (int i = 0; i <= LAT; i++) step(1'b0, 1'b0, (i < LAT), 1'b1, $sformatf("t3_fall_%0d", i));
    check_cnt("t3_cnt", CNT_ON ? CW'(1) : CW'(0));

    // Acknowledge clears; idle ack is harmless; rise beats a coincident ack
    step(1'b0, 1'b1, 1'b0, 1'b0, "t4_ack");
    step(1'b0, 1'b1, 1'b0, 1'b0, "t4_idle_ack");
    for (int i = 0; i <= LAT; i++) step(1'b1, 1'b0, (i >= LAT), 1'b0, $sformatf("t4_rise_%0d", i));
    step(1'b1, 1'b1, 1'b1, 1'b1, "t4_rise_ack");
    step(1'b1, 1'b1, 1'b1, 1'b0, "t4_ack2");
    check_cnt("t4_cnt", CNT_ON ? CW'(2) : CW'(0));

    // Saturating arrival counter
    do_reset();
    for (int a = 0; a < 260; a++) begin
      drive(1'b1, 8);
      drive(1'b0, 8);
      if (a == 99) check_cnt("t5_cnt100", CNT_ON ? CW'(100) : CW'(0));
    end
    check_cnt("t5_cnt_sat", CNT_ON ? CW'(255) : CW'(0));

    // Reset in the middle of a confirm (car_req still pending from the last test)
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, $sformatf("t6_conf_%0d", i));
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, "t6_reset");
    check_cnt("t6_rst_cnt", '0);
    reset = 1'b0;
    for (int i = 0; i <= LAT + 1; i++) begin
      step(1'b1, 1'b0, (i >= LAT), (i >= LAT + 1), $sformatf("t6_post_%0d", i));
    end
    check_cnt("t6_cnt", CNT_ON ? CW'(1) : CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
